// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: measures period and high time of div_clk in clk cycles,
// compares against the expected ratio, and reports lock, mismatches, an error
// count and a sticky stall timeout.
module div_clk_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 4,
    parameter int unsigned EXP_HIGH   = 2,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_clk,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch,
    output logic [7:0]       err_count,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ExpPeriodW = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] ExpHighW   = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] TimeoutW   = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LockW      = 4'(LOCK_COUNT);

    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic             armed_q;
    logic [3:0]       match_cnt_q;

    logic             rise;
    logic             is_match;
    logic             hit_timeout;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcnt_inc;
    logic [3:0]       match_inc;
    logic [7:0]       err_inc;

    // Edge detect, match test and saturating increments.
    always_comb begin
        rise     = div_clk & ~div_q;
        is_match = (cnt_q == ExpPeriodW) && (hcnt_q == ExpHighW);
        cnt_inc  = (cnt_q >= TimeoutW) ? TimeoutW : cnt_q + CntOne;
        hcnt_inc = (div_clk && (hcnt_q != '1)) ? hcnt_q + CntOne : hcnt_q;
        // Fires only on the transition into TIMEOUT, not while saturated there.
        hit_timeout = !rise && (cnt_q == TimeoutW - CntOne);
        match_inc   = (match_cnt_q >= LockW) ? LockW : match_cnt_q + 4'd1;
        err_inc     = (err_count == 8'hff) ? err_count : err_count + 8'd1;
    end

    // Measurement, lock tracking, error counting and stall detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q       <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            armed_q     <= 1'b0;
            match_cnt_q <= 4'd0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            mismatch    <= 1'b0;
            err_count   <= 8'd0;
            timeout     <= 1'b0;
        end else begin
            div_q      <= div_clk;
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            if (rise) begin
                cnt_q   <= CntOne;
                hcnt_q  <= CntOne;
                armed_q <= 1'b1;
                // First edge after reset or a stall only arms the block.
                if (armed_q) begin
                    period     <= cnt_q;
                    high_time  <= hcnt_q;
                    meas_valid <= 1'b1;
                    if (is_match) begin
                        match_cnt_q <= match_inc;
                        if (match_inc == LockW) begin
                            locked <= 1'b1;
                        end
                    end else begin
                        match_cnt_q <= 4'd0;
                        locked      <= 1'b0;
                        mismatch    <= 1'b1;
                        err_count   <= err_inc;
                    end
                end
            end else begin
                cnt_q  <= cnt_inc;
                hcnt_q <= hcnt_inc;
                if (hit_timeout) begin
                    timeout     <= 1'b1;
                    locked      <= 1'b0;
                    match_cnt_q <= 4'd0;
                    armed_q     <= 1'b0;
                end
            end
            // Clear takes priority over a same-cycle mismatch or stall.
            if (clr) begin
                err_count <= 8'd0;
                timeout   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor with hand-computed expectations.
`timescale 1ns / 100ps
module tb_div_clk_monitor;

    logic       clk;
    logic       reset;
    logic       div_clk;
    logic       clr;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       meas_valid;
    logic       locked;
    logic       mismatch;
    logic [7:0] err_count;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Outputs captured on the rising-edge step of each waveform period.
    logic       mv, mv2, mm, lk;
    logic [7:0] pr, ht;

    div_clk_monitor #(
        .CNT_W      (8),
        .EXP_PERIOD (4),
        .EXP_HIGH   (2),
        .LOCK_COUNT (3),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .div_clk    (div_clk),
        .clr        (clr),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .mismatch   (mismatch),
        .err_count  (err_count),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive inputs at the falling edge; return 1 ns after the next rising edge.
    task automatic step(input logic d, input logic c);
        @(negedge clk);
        div_clk = d;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    // One waveform period: hi cycles high then lo cycles low. The rise step
    // reports the measurement of the previous period.
    task automatic cycle(input int hi, input int lo, input logic c);
        step(1'b1, c);
        mv = meas_valid;
        pr = period;
        ht = high_time;
        mm = mismatch;
        lk = locked;
        for (int i = 1; i < hi; i++) begin
            step(1'b1, 1'b0);
            if (i == 1) mv2 = meas_valid;
        end
        for (int i = 0; i < lo; i++) begin
            step(1'b0, 1'b0);
            if (i == 0 && hi == 1) mv2 = meas_valid;
        end
    endtask

    initial begin
        reset   = 1'b0;
        div_clk = 1'b0;
        clr     = 1'b0;
        #5;
        check_eq("rst_period", 32'(period), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_err", 32'(err_count), 0);
        check_eq("rst_timeout", 32'(timeout), 0);
        check_eq("rst_meas_valid", 32'(meas_valid), 0);
        #25;
        reset = 1'b1;

        // Clean divide-by-4.
        cycle(2, 2, 1'b0);
        check_eq("arm_no_meas", 32'(mv), 0);
        cycle(2, 2, 1'b0);
        check_eq("d4_mv", 32'(mv), 1);
        check_eq("d4_mv_pulse", 32'(mv2), 0);
        check_eq("d4_period", 32'(pr), 4);
        check_eq("d4_high", 32'(ht), 2);
        check_eq("d4_lk1", 32'(lk), 0);
        cycle(2, 2, 1'b0);
        check_eq("d4_lk2", 32'(lk), 0);
        cycle(2, 2, 1'b0);
        check_eq("d4_lk3", 32'(lk), 1);
        check_eq("d4_err", 32'(err_count), 0);

        // Divide-by-6 while locked.
        for (int k = 1; k <= 5; k++) begin
            cycle(3, 3, 1'b0);
            if (k == 1) check_eq("d6_prev_match", 32'(mm), 0);
            if (k == 2) begin
                check_eq("d6_period", 32'(pr), 6);
                check_eq("d6_high", 32'(ht), 3);
                check_eq("d6_mismatch", 32'(mm), 1);
                check_eq("d6_unlock", 32'(lk), 0);
            end
            if (k >= 2) check_eq("d6_err", 32'(err_count), 32'(k - 1));
        end
        cycle(2, 2, 1'b0);
        check_eq("d6_err5", 32'(err_count), 5);
        cycle(2, 2, 1'b0);
        cycle(2, 2, 1'b0);
        check_eq("relock_2", 32'(lk), 0);
        cycle(2, 2, 1'b0);
        check_eq("relock_3", 32'(lk), 1);

        // Duty error: period 4, 3 high / 1 low.
        for (int k = 1; k <= 5; k++) begin
            cycle(3, 1, 1'b0);
            if (k >= 2) begin
                check_eq("duty_high", 32'(ht), 3);
                check_eq("duty_mm", 32'(mm), 1);
                check_eq("duty_lk", 32'(lk), 0);
            end
        end
        cycle(2, 2, 1'b0);
        check_eq("duty_err", 32'(err_count), 10);
        for (int k = 0; k < 3; k++) cycle(2, 2, 1'b0);
        check_eq("pre_to_locked", 32'(locked), 1);

        // Stall: rise edge plus 3 edges already elapsed; timeout at edge 63.
        for (int k = 0; k < 59; k++) step(1'b0, 1'b0);
        check_eq("to_not_yet", 32'(timeout), 0);
        check_eq("to_lk_before", 32'(locked), 1);
        step(1'b0, 1'b0);
        check_eq("to_set", 32'(timeout), 1);
        check_eq("to_unlock", 32'(locked), 0);
        check_eq("to_err_kept", 32'(err_count), 10);
        cycle(2, 2, 1'b0);
        check_eq("to_rearm", 32'(mv), 0);
        cycle(2, 2, 1'b0);
        check_eq("to_meas_mv", 32'(mv), 1);
        check_eq("to_meas_period", 32'(pr), 4);
        check_eq("to_sticky", 32'(timeout), 1);
        cycle(2, 1, 1'b0);
        step(1'b0, 1'b1);
        check_eq("clr_timeout", 32'(timeout), 0);
        check_eq("clr_err", 32'(err_count), 0);

        // Build up err_count = 3 while locked, then reset mid-period.
        for (int k = 0; k < 3; k++) cycle(3, 3, 1'b0);
        for (int k = 0; k < 4; k++) cycle(2, 2, 1'b0);
        check_eq("pre_rst_err", 32'(err_count), 3);
        check_eq("pre_rst_lk", 32'(locked), 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #3;
        reset   = 1'b0;
        div_clk = 1'b0;
        #1;
        check_eq("arst_period", 32'(period), 0);
        check_eq("arst_high", 32'(high_time), 0);
        check_eq("arst_locked", 32'(locked), 0);
        check_eq("arst_err", 32'(err_count), 0);
        check_eq("arst_timeout", 32'(timeout), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // clr on the same edge as a mismatch.
        cycle(2, 2, 1'b0);
        check_eq("post_rst_arm", 32'(mv), 0);
        cycle(3, 3, 1'b0);
        cycle(3, 3, 1'b0);
        check_eq("pre_clr_err", 32'(err_count), 1);
        cycle(2, 2, 1'b1);
        check_eq("clr_mm_pulse", 32'(mm), 1);
        check_eq("clr_mm_err", 32'(err_count), 0);

        // Saturation of err_count.
        for (int k = 1; k <= 258; k++) begin
            cycle(3, 1, 1'b0);
            if (k == 255) check_eq("err_254", 32'(err_count), 254);
            if (k == 256) check_eq("err_255", 32'(err_count), 255);
            if (k == 258) check_eq("err_sat", 32'(err_count), 255);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Receive-side checker for divided clocks produced by the frequency-divider blocks. It samples a divided clock in the `clk` domain, measures period and high time in `clk` cycles, and compares each measurement against the expected ratio. It reports lock, per-period mismatch, a saturating error count and a stall timeout. It sits beside each divider instance as a built-in self-check and as a reusable bench monitor.

## Interface
- `CNT_W`, 8 — width of the period and high-time counters.
- `EXP_PERIOD`, 4 — expected period in `clk` cycles.
- `EXP_HIGH`, 2 — expected high time in `clk` cycles.
- `LOCK_COUNT`, 3 — consecutive matching periods required to assert lock (1..15).
- `TIMEOUT`, 64 — cycles without a rising edge that declare a stall (2..2^CNT_W−1).

- `clk` in 1 — system clock; rising-edge active.
- `reset` in 1 — asynchronous, active-low reset.
- `div_clk` in 1 — divided clock under test; synchronous to `clk`.
- `clr` in 1 — synchronous clear of `err_count` and `timeout`.
- `period` out CNT_W — last measured period.
- `high_time` out CNT_W — last measured high time.
- `meas_valid` out 1 — one-cycle pulse when `period`/`high_time` update.
- `locked` out 1 — LOCK_COUNT consecutive matches seen.
- `mismatch` out 1 — one-cycle pulse on a non-matching measurement.
- `err_count` out 8 — saturating count of mismatches.
- `timeout` out 1 — sticky stall flag.

## Operation
- Internal registers:
  - `div_q`: `div_clk` delayed one cycle.
  - `cnt`, `hcnt`: CNT_W-bit counters.
  - `armed`: 1 bit.
  - `match_cnt`: 4 bits.
- Rising-edge detect: `rise = div_clk & ~div_q` (combinational).
- On `rise`:
  - If `armed`:
    - Load `period <= cnt` and `high_time <= hcnt`, and pulse `meas_valid`.
    - Match when `cnt == EXP_PERIOD` and `hcnt == EXP_HIGH`.
  - Then `cnt <= 1`, `hcnt <= 1`, `armed <= 1`.
  - `timeout` stays set until `clr` or reset.
- Without `rise`:
  - `cnt` increments, saturating at TIMEOUT.
  - `hcnt` increments when `div_clk` is 1, saturating at 2^CNT_W−1.
- The first rising edge after reset or timeout only arms the block; it produces no measurement.
- On a match: `match_cnt` increments, saturating at LOCK_COUNT. `locked` becomes 1 on the edge where `match_cnt` reaches LOCK_COUNT.
- On a mismatch:
  - `match_cnt <= 0` and `locked <= 0`.
  - `mismatch` pulses.
  - `err_count` increments, saturating at 255.
- Timeout: on the edge where `cnt` reaches TIMEOUT without `rise`:
  - `timeout <= 1`, `locked <= 0`, `match_cnt <= 0`, `armed <= 0`.
  - `err_count` is unaffected.
- `clr` zeroes `err_count` and `timeout`. When `clr` coincides with a mismatch or timeout, `clr` wins: `err_count` = 0 and `timeout` = 0. `locked` and `mismatch` still follow the mismatch or timeout.
- Reset:
  - All outputs and internal registers go to 0, including `div_q` and `armed`.
  - Asserting reset mid-measurement discards the partial count.
  - After release, `cnt` counts from 0, so timeout fires TIMEOUT cycles after release if no edge arrives.

## Timing
- Detect latency: `div_clk` sampled high at edge k with `div_q` = 0 → `period`, `high_time`, `meas_valid`, `mismatch` and `locked` are all valid after edge k, i.e. zero extra cycles.
- `meas_valid` and `mismatch` are high exactly one cycle. `locked` and `timeout` are levels.
- For a divide-by-4 waveform, `rise` occurs every 4 edges, giving `period` = 4 and `high_time` = 2.
- Timeout asserts TIMEOUT−1 edges after the last `rise` edge.
- Minimum measurable period is 2. A constant-high `div_clk` produces no `rise` and ends in timeout.

## Test plan
- Clean divide-by-4 (`clk` period 25 ns, reset low for 30 ns):
  - First `rise` arms only.
  - `meas_valid` then pulses every 4 cycles with `period` = 4, `high_time` = 2.
  - `locked` rises on the 3rd measurement; `err_count` stays 0.
- Switch stimulus to divide-by-6 (3 high / 3 low) while locked:
  - First measurement is `period` = 6, `high_time` = 3, with `mismatch` pulsing and `locked` falling.
  - `err_count` increments by 1 per period, with `err_count` = 5 after 5 periods.
  - Return to divide-by-4 → `locked` again after 3 matches.
- Duty error, period 4 with 3 high / 1 low → every measurement mismatches with `high_time` = 3; `locked` never asserts.
- Hold `div_clk` low after a `rise` → `timeout` = 1 at the 63rd edge and `locked` = 0. Resume divide-by-4:
  - The first `rise` gives no `meas_valid`.
  - The next gives `period` = 4.
  - `timeout` stays 1 until `clr`.
- Assert `reset` mid-period while locked with `err_count` = 3 → all outputs 0 immediately. Then:
  - Pulse `clr` on the same cycle as a mismatch → `err_count` = 0.
  - Drive `err_count` past 255 → it holds at 255.
